// File: rtl/regfile_pkg.sv
// Shared constants and the one-hot decode helper for the multi-port register file.
package regfile_pkg;

   localparam int unsigned DEFAULT_WIDTH = 16;
   localparam int unsigned DEFAULT_DEPTH = 8;
   localparam int unsigned MAX_DEPTH     = 256;
   localparam int unsigned MAX_AW        = 8;

   // True when bit position pos of the one-hot code for addr is set.
   function automatic logic onehot(input logic [MAX_AW-1:0] addr, input int unsigned pos);
      return (32'(addr) == pos);
   endfunction

endpackage

// File: rtl/regfile_mp_onehot_dec.sv
// Write-address decoder: one-hot enable vector, all zeros when disabled or out of range.
module onehot_dec
   import regfile_pkg::*;
#(
   parameter int unsigned AW    = 3,
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input  logic [AW-1:0]    addr,
   input  logic             en,
   output logic [DEPTH-1:0] onehot_c
);

   // Bit positions only exist below DEPTH, so addresses >= DEPTH decode to zero.
   always_comb begin
      onehot_c = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         onehot_c[i] = en & onehot(MAX_AW'(addr), i);
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Register file with one write port, two combinational read ports, per-entry
// valid bits, synchronous bulk invalidate and optional write-to-read forwarding.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH  = DEFAULT_WIDTH,
   parameter int unsigned DEPTH  = DEFAULT_DEPTH,
   parameter bit          BYPASS = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         data_in,
   input  logic [$clog2(DEPTH)-1:0] writenum,
   input  logic                     write,
   input  logic                     clear,
   input  logic [$clog2(DEPTH)-1:0] readnum_a,
   input  logic [$clog2(DEPTH)-1:0] readnum_b,
   output logic [WIDTH-1:0]         data_out_a,
   output logic [WIDTH-1:0]         data_out_b,
   output logic                     valid_a,
   output logic                     valid_b,
   output logic [DEPTH-1:0]         load
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] vbit;
   logic             hit_a;
   logic             hit_b;

   onehot_dec #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_dec (
      .addr     (writenum),
      .en       (write),
      .onehot_c (load)
   );

   // Storage; clear drops every valid bit except the one being written this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         vbit <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (load[i]) begin
               regs[i] <= data_in;
            end
         end
         vbit <= clear ? load : (vbit | load);
      end
   end

   // Forward only in-range writes; an out-of-range writenum never produces a hit.
   always_comb begin
      hit_a = BYPASS && write && (writenum == readnum_a) && (32'(readnum_a) < DEPTH);
      hit_b = BYPASS && write && (writenum == readnum_b) && (32'(readnum_b) < DEPTH);
   end

   // Read ports; unmatched (out-of-range) addresses fall through to zero.
   always_comb begin
      data_out_a = '0;
      data_out_b = '0;
      valid_a    = 1'b0;
      valid_b    = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (readnum_a == AW'(i)) begin
            data_out_a = regs[i];
            valid_a    = vbit[i];
         end
         if (readnum_b == AW'(i)) begin
            data_out_b = regs[i];
            valid_b    = vbit[i];
         end
      end
      if (hit_a) begin
         data_out_a = data_in;
         valid_a    = 1'b1;
      end
      if (hit_b) begin
         data_out_b = data_in;
         valid_b    = 1'b1;
      end
      // Forwarding is suppressed while reset is held so outputs stay quiet.
      if (!rst_n) begin
         data_out_a = '0;
         data_out_b = '0;
         valid_a    = 1'b0;
         valid_b    = 1'b0;
      end
   end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of registers (2..256, not required to be a power of two).
REQ-003 SHALL have parameter BYPASS, default 1, which enables write-to-read forwarding when set to 1.
REQ-004 SHALL derive localparam AW = $clog2(DEPTH), the address width.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: one clock, reset is asynchronous and active-low.
REQ-007 SHALL have port data_in, input, WIDTH bits: write data.
REQ-008 SHALL have port writenum, input, AW bits: write address.
REQ-009 SHALL have port write, input, 1 bit: write enable.
REQ-010 SHALL have port clear, input, 1 bit: synchronous invalidate of all registers.
REQ-011 SHALL have ports readnum_a and readnum_b, inputs, AW bits each: read addresses.
REQ-012 SHALL have ports data_out_a and data_out_b, outputs, WIDTH bits each: read data.
REQ-013 SHALL have ports valid_a and valid_b, outputs, 1 bit each: addressed register holds a written value.
REQ-014 SHALL have port load, output, DEPTH bits: one-hot write-enable vector, exposed for observation.

Function
REQ-015 SHALL drive load = one-hot(writenum) when write=1 and writenum<DEPTH, else all zeros, combinationally.
REQ-016 SHALL capture data_in into register writenum on the rising clk edge when load[writenum]=1; no other register changes.
REQ-017 SHALL ignore writes with writenum>=DEPTH: no register or valid bit changes.
REQ-018 SHALL keep one valid bit per register: set on write, cleared on clear.
REQ-019 SHALL make reads combinational and independent of clk: data_out_x = reg[readnum_x], valid_x = vbit[readnum_x], with zero clock latency.
REQ-020 SHALL return data_out_x=0 and valid_x=0 when readnum_x>=DEPTH.
REQ-021 SHALL, with BYPASS=1 and write=1 and writenum==readnum_x<DEPTH, drive data_out_x=data_in and valid_x=1 in the same cycle, before the edge.
REQ-022 SHALL, with BYPASS=0, show new data only after the capturing edge.
REQ-023 SHALL allow both read ports to address the same register, or the register being written, simultaneously without conflict.
REQ-024 SHALL, when clear=1 and write=1 in the same cycle, clear all valid bits except the written register, which ends valid with the new data (write wins).
REQ-025 SHALL leave register contents unchanged on clear; only the valid bits are cleared.
REQ-026 SHALL, under BYPASS=1 with clear=1 and write=1, still forward the write to matching read ports.

Reset
REQ-027 SHALL, on rst_n low, asynchronously set all registers to 0 and all valid bits to 0, independent of clk.
REQ-028 SHALL hold outputs during reset at data_out_x=0 and valid_x=0; load still follows REQ-015.
REQ-029 SHALL drop a write that coincides with reset assertion, and accept the first write on the first rising edge after rst_n goes high.

Structure
REQ-030 SHALL place the default WIDTH and DEPTH constants and a onehot decode function in the shared package regfile_pkg.
REQ-031 SHALL implement the write-address decode as sub-module onehot_dec #(AW, DEPTH); registers and valid bits stay inline.

Verification
REQ-032 SHALL cover reset: assert rst_n=0 mid-cycle -> all registers read 0 and valid_a=valid_b=0 immediately, with no wait for a clock edge.
REQ-033 SHALL cover write/read: write 42 to r3 -> load=8'b00001000 before the edge; after the edge, readnum_a=3 gives 42 with valid_a=1; write=0 gives load=0.
REQ-034 SHALL cover bypass: BYPASS=1, write 69 to r1, readnum_a=readnum_b=1 before the edge -> both outputs 69 and valid=1 pre-edge. BYPASS=0 instance: outputs 0 and valid=0 pre-edge, 69 and valid=1 post-edge.
REQ-035 SHALL cover clear with write: r2=5 valid, then clear=1 together with writing 420 to r4 -> r2 still reads 5 with valid=0; r4 reads 420 with valid=1.
REQ-036 SHALL cover out-of-range access: DEPTH=6, write 7 to writenum=6 -> load=0 and no register changes; readnum_a=7 gives data_out_a=0 and valid_a=0.
REQ-037 SHALL cover dual read during write: write 420 to r2 while readnum_a=3 (holding 42) and readnum_b=2 -> after the edge, data_out_a=42 and data_out_b=420.
